// File: rtl/operand_loader.sv
// operand_loader
//   Receives a 128-byte operand frame as a byte stream and distributes it to
//   a modular exponentiator. The frame is four 32-byte words, each sent most
//   significant byte first: M (modulus), e (exponent), x_bar (initial
//   Montgomery accumulator) and M_bar (Montgomery-domain message).
//   M and e are held in registers. x_bar and M_bar are written to the operand
//   RAM. After the frame, the most significant set bit of e is located. The
//   exponentiator is then started and the loader waits for its stop flag.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_data/in_valid    byte stream input
//   in_ready            high only in LOAD. Handshake rule: a byte is
//                       consumed on any rising edge where in_valid and
//                       in_ready are both high. in_valid while in_ready is
//                       low is ignored, and that byte stays pending.
//   M, e                operand registers for the exponentiator
//   e_idx               index of the most significant set bit of e
//   wr_addr/wr_data/wr_en  operand RAM write port (one-cycle strobes)
//   exp_start           one-cycle start pulse to the exponentiator
//   exp_stop            exponentiator stop flag (level, sticky)
//   busy                high in every state except LOAD
//   done                one-cycle pulse when the exponentiation completes
//   err                 sticky: the last frame carried e == 0
module operand_loader #(
    parameter int ABITS     = 8,
    parameter int DBITS     = 256,
    parameter int X_ADDR    = 0,
    parameter int MBAR_ADDR = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DBITS-1:0] M,
    output logic [DBITS-1:0] e,
    output logic [7:0]       e_idx,
    output logic [ABITS-1:0] wr_addr,
    output logic [DBITS-1:0] wr_data,
    output logic             wr_en,
    output logic             exp_start,
    input  logic             exp_stop,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {LOAD, SCAN, START, BUSY} state_t;

    state_t           state;
    logic [6:0]       byte_cnt;
    logic [DBITS-1:0] shreg;
    logic [7:0]       idx;
    logic             stop_q;
    logic             xfer;
    logic [DBITS-1:0] word;

    assign in_ready = (state == LOAD);
    assign busy     = (state != LOAD);
    assign xfer     = in_valid && in_ready;
    // Word as it stands once the current byte has been shifted in. It is used
    // at the word-completing byte, so the register loads see the whole word
    // without waiting an extra cycle.
    assign word     = {shreg[DBITS-9:0], in_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= LOAD;
            byte_cnt  <= '0;
            shreg     <= '0;
            M         <= '0;
            e         <= '0;
            e_idx     <= '0;
            err       <= 1'b0;
            idx       <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            exp_start <= 1'b0;
            done      <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            exp_start <= 1'b0;
            done      <= 1'b0;
            stop_q    <= exp_stop;

            case (state)
                LOAD: begin
                    if (xfer) begin
                        shreg    <= word;
                        byte_cnt <= byte_cnt + 7'd1;  // wraps 127 -> 0
                        if (byte_cnt == 7'd0) begin
                            err <= 1'b0;
                        end
                        case (byte_cnt)
                            7'd31: M <= word;
                            7'd63: e <= word;
                            7'd95: begin
                                wr_en   <= 1'b1;
                                wr_addr <= ABITS'(X_ADDR);
                                wr_data <= word;
                            end
                            7'd127: begin
                                wr_en   <= 1'b1;
                                wr_addr <= ABITS'(MBAR_ADDR);
                                wr_data <= word;
                                idx     <= 8'd255;
                                state   <= SCAN;
                            end
                            default: ;
                        endcase
                    end
                end

                // Test one bit per cycle, starting at the top. idx == 0 with a
                // clear bit means e == 0, and there is nothing to start.
                SCAN: begin
                    if (e[idx]) begin
                        e_idx     <= idx;
                        exp_start <= 1'b1;
                        state     <= START;
                    end else if (idx == 8'd0) begin
                        err   <= 1'b1;
                        e_idx <= 8'd0;
                        state <= LOAD;
                    end else begin
                        idx <= idx - 8'd1;
                    end
                end

                // exp_start was raised on the way in and is high for this one
                // cycle only.
                START: state <= BUSY;

                // Only a fresh rising edge completes the operation. A stop flag
                // still high from the previous operation must not.
                BUSY: begin
                    if (exp_stop && !stop_q) begin
                        done  <= 1'b1;
                        state <= LOAD;
                    end
                end

                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;

    localparam int ABITS     = 8;
    localparam int DBITS     = 256;
    localparam int X_ADDR    = 0;
    localparam int MBAR_ADDR = 1;
    localparam int W         = ABITS + DBITS;

    logic             clk;
    logic             rst_n;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [DBITS-1:0] M;
    logic [DBITS-1:0] e;
    logic [7:0]       e_idx;
    logic [ABITS-1:0] wr_addr;
    logic [DBITS-1:0] wr_data;
    logic             wr_en;
    logic             exp_start;
    logic             exp_stop;
    logic             busy;
    logic             done;
    logic             err;

    operand_loader #(
        .ABITS(ABITS), .DBITS(DBITS), .X_ADDR(X_ADDR), .MBAR_ADDR(MBAR_ADDR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .M(M), .e(e), .e_idx(e_idx), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_en(wr_en), .exp_start(exp_start),
        .exp_stop(exp_stop), .busy(busy), .done(done), .err(err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // RAM writes are compared in order against what the frame must produce.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ram_write", {wr_addr, wr_data}, '0);
                end else begin
                    check("ram_write", {wr_addr, wr_data}, exp_q.pop_front());
                end
            end
            if (exp_start) start_cnt++;
            if (done) done_cnt++;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] msb_of(input logic [255:0] v);
        logic [7:0] r = 8'd0;
        for (int i = 0; i < 256; i++) if (v[i]) r = 8'(i);
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [255:0] m;
        logic [255:0] ev;
        logic [255:0] x;
        logic [255:0] mb;
        bit           toggle;
        bit           held;
        logic [7:0]   idx;
        bit           zero;
    } vec_t;

    task automatic run_frame(input vec_t v, input string tag);
        logic [255:0] words[4];
        int s0, d0, c, exp_cycles;
        words[0] = v.m; words[1] = v.ev; words[2] = v.x; words[3] = v.mb;
        if (!v.held) exp_stop = 1'b0;
        exp_q.push_back({ABITS'(X_ADDR), v.x});
        exp_q.push_back({ABITS'(MBAR_ADDR), v.mb});
        s0 = start_cnt;
        d0 = done_cnt;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 32; b++) begin
                send_byte(words[w][255 - 8*b -: 8]);
                if (w == 0 && b == 0) check({tag, "_err_cleared"}, err, 0);
                if (v.toggle && !(w == 3 && b == 31)) begin
                    @(posedge clk); #1;
                end
            end
        end
        check({tag, "_M"}, M, v.m);
        check({tag, "_e"}, e, v.ev);
        check({tag, "_busy_scan"}, busy, 1);

        c = 0;
        while (!exp_start && !in_ready && c < 400) begin
            @(posedge clk); #1;
            c++;
        end
        exp_cycles = v.zero ? 256 : 256 - int'(v.idx);
        check({tag, "_scan_cycles"}, c, exp_cycles);
        check({tag, "_e_idx"}, e_idx, v.idx);
        check({tag, "_err"}, err, v.zero);

        if (v.zero) begin
            check({tag, "_ready_again"}, in_ready, 1);
            @(posedge clk); #1;
            check({tag, "_no_start"}, start_cnt - s0, 0);
        end else begin
            @(posedge clk); #1;
            check({tag, "_start_one_cycle"}, exp_start, 0);
            if (v.held) begin
                repeat (30) @(posedge clk);
                #1;
                check({tag, "_no_done_level_high"}, done_cnt - d0, 0);
                check({tag, "_still_busy"}, busy, 1);
                exp_stop = 1'b0;
                @(posedge clk); #1;
            end
            repeat (18) @(posedge clk);
            #1;
            check({tag, "_regs_stable_busy"}, {M ^ e, e_idx}, {v.m ^ v.ev, v.idx});
            exp_stop = 1'b1;
            c = 0;
            while (!done && c < 50) begin
                @(posedge clk); #1;
                c++;
            end
            check({tag, "_done_seen"}, done, 1);
            @(posedge clk); #1;
            check({tag, "_done_pulse"}, done, 0);
            check({tag, "_back_to_load"}, in_ready, 1);
            check({tag, "_start_count"}, start_cnt - s0, 1);
            check({tag, "_done_count"}, done_cnt - d0, 1);
        end
        check({tag, "_ram_writes_drained"}, exp_q.size(), 0);
    endtask

    // ---------------- test ----------------
    vec_t tbl[6];
    vec_t rv;
    logic [255:0] fb_m;

    initial begin
        in_data  = 8'h00;
        in_valid = 1'b0;
        exp_stop = 1'b0;
        rst_n    = 1'b1;

        fb_m = {{31{8'hFF}}, 8'hFB};
        tbl[0] = '{fb_m, 256'h10001, 256'h05, 256'h07, 1'b0, 1'b0, 8'd16, 1'b0};
        tbl[1] = '{fb_m, 256'h10001, 256'h05, 256'h07, 1'b1, 1'b1, 8'd16, 1'b0};
        tbl[2] = '{256'h1234_5678, 256'h1 << 255, 256'hAA, 256'hBB, 1'b0, 1'b0, 8'd255, 1'b0};
        tbl[3] = '{256'hCAFE, 256'h1, 256'h11, 256'h22, 1'b0, 1'b0, 8'd0, 1'b0};
        tbl[4] = '{256'hBEEF, 256'h0, 256'h33, 256'h44, 1'b0, 1'b0, 8'd0, 1'b1};
        tbl[5] = '{256'hD00D_F00D, 256'h8000_0000, 256'h55, 256'h66, 1'b1, 1'b0, 8'd31, 1'b0};

        do_reset();
        check("rst_M", M, 0);
        check("rst_e", e, 0);
        check("rst_e_idx", e_idx, 0);
        check("rst_err", err, 0);
        check("rst_flags", {wr_en, exp_start, done, busy, in_ready}, 5'b00001);

        for (int i = 0; i < 5; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of a frame: nothing of the partial frame survives.
        for (int b = 0; b < 70; b++) send_byte(8'($urandom_range(0, 255)));
        do_reset();
        check("midrst_M", M, 0);
        check("midrst_e", e, 0);
        check("midrst_err_idx", {err, e_idx}, 0);
        check("midrst_ready", in_ready, 1);
        run_frame(tbl[5], "after_rst");

        // Randomized frames against the model.
        for (int n = 0; n < 4; n++) begin
            int k;
            for (int j = 0; j < 8; j++) begin
                rv.m[32*j +: 32]  = $urandom;
                rv.ev[32*j +: 32] = $urandom;
                rv.x[32*j +: 32]  = $urandom;
                rv.mb[32*j +: 32] = $urandom;
            end
            k = $urandom_range(0, 255);
            rv.ev = (rv.ev >> (255 - k)) | (256'h1 << k);
            rv.toggle = 1'($urandom_range(0, 1));
            rv.held   = 1'b0;
            rv.idx    = msb_of(rv.ev);
            rv.zero   = (rv.ev == 0);
            run_frame(rv, $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
